// File: rtl/axis_burst_pkg.sv
// axis_burst_pkg
//   Shared types and constants for the AXI-Stream burst source.
//   - state_t       : burst FSM states (IDLE, SEND)
//   - DEF_DATA_WIDTH: default stream data width
//   - DEF_LEN_WIDTH : default command length width
//   - BURST_CNT_W   : width of the completed-burst counter
package axis_burst_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int BURST_CNT_W    = 16;

endpackage

// File: rtl/axis_burst_source.sv
// axis_burst_source
//   AXI-Stream master that expands one command (start value, length-1) into
//   a burst of incrementing data beats, with out_last on the final beat.
//   A command presented during the final beat's handshake loads directly,
//   so consecutive bursts stream with no idle cycle between them.
//
// Ports
//   clk, resetn     : clock, asynchronous active-low reset
//   cmd_start       : data value of the first beat
//   cmd_len         : beats in burst minus one
//   cmd_valid/ready : command handshake (cmd_ready is combinational)
//   out_data/valid/ready/last : AXI-Stream master port, outputs registered
//   done            : one-cycle pulse after a final-beat handshake
//   burst_count     : completed bursts, wraps modulo 2^16
module axis_burst_source
    import axis_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DATA_WIDTH-1:0]  cmd_start,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   done,
    output logic [BURST_CNT_W-1:0] burst_count
);

    localparam logic [DATA_WIDTH-1:0]  DATA_ONE = DATA_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]   LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [BURST_CNT_W-1:0] CNT_ONE  = BURST_CNT_W'(1);

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;   // beats left after the one on the bus

    logic beat_hs;
    logic last_hs;
    logic accept;

    assign beat_hs = out_valid && out_ready;
    assign last_hs = beat_hs && out_last;

    // Ready either when idle or while the current burst retires this cycle,
    // which is what lets the next burst follow without a bubble. Held low
    // during reset so no command can be taken while the block is cleared.
    assign cmd_ready = resetn && ((state == IDLE) || last_hs);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            burst_count <= '0;
            remaining   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_data  <= cmd_start;
                        remaining <= cmd_len;
                        out_last  <= (cmd_len == '0);
                    end
                end
                SEND: begin
                    if (beat_hs) begin
                        if (!out_last) begin
                            out_data  <= out_data + DATA_ONE;
                            remaining <= remaining - LEN_ONE;
                            out_last  <= (remaining == LEN_ONE);
                        end else begin
                            done        <= 1'b1;
                            burst_count <= burst_count + CNT_ONE;
                            if (accept) begin
                                // chained burst: out_valid stays high
                                out_data  <= cmd_start;
                                remaining <= cmd_len;
                                out_last  <= (cmd_len == '0);
                            end else begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_burst_source.sv
// tb_axis_burst_source
//   Directed bench for axis_burst_source. Outputs are sampled on the falling
//   edge and inputs are driven right after sampling, so each rising edge sees
//   stable stimulus. Expected values are hand-computed constants.
module tb_axis_burst_source;
    import axis_burst_pkg::*;

    logic                   clk;
    logic                   resetn;
    logic [7:0]             cmd_start;
    logic [7:0]             cmd_len;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   done;
    logic [BURST_CNT_W-1:0] burst_count;

    int n_vec = 0;
    int n_err = 0;
    int n_hs  = 0;

    axis_burst_source #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_start   (cmd_start),
        .cmd_len     (cmd_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .done        (done),
        .burst_count (burst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " data"},  32'(out_data),  32'(d));
        chk({tag, " last"},  32'(out_last),  32'(l));
    endtask

    // Present a command at the current falling edge; accepted at the next rise.
    task automatic issue(input logic [7:0] s, input logic [7:0] l);
        cmd_start = s;
        cmd_len   = l;
        cmd_valid = 1'b1;
        chk("cmd_ready at issue", 32'(cmd_ready), 32'd1);
    endtask

    logic [7:0] bp_data [6] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02};
    logic       bp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       bp_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] d8;

    initial begin
        resetn = 1'b0; cmd_start = '0; cmd_len = '0; cmd_valid = 1'b0; out_ready = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst out_valid",   32'(out_valid),   32'd0);
        chk("rst out_data",    32'(out_data),    32'd0);
        chk("rst out_last",    32'(out_last),    32'd0);
        chk("rst done",        32'(done),        32'd0);
        chk("rst burst_count", 32'(burst_count), 32'd0);
        chk("rst cmd_ready",   32'(cmd_ready),   32'd0);
        resetn = 1'b1;

        // idle with out_ready high: nothing happens
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle out_valid", 32'(out_valid), 32'd0);
        chk("idle cmd_ready", 32'(cmd_ready), 32'd1);

        // single burst 0x10, len 3
        issue(8'h10, 8'd3);
        @(negedge clk); cmd_valid = 1'b0;
        beat("s1 b0", 8'h10, 1'b0);
        chk("s1 cmd_ready busy", 32'(cmd_ready), 32'd0);
        @(negedge clk); beat("s1 b1", 8'h11, 1'b0);
        @(negedge clk); beat("s1 b2", 8'h12, 1'b0);
        @(negedge clk); beat("s1 b3", 8'h13, 1'b1);
        chk("s1 done early", 32'(done), 32'd0);
        @(negedge clk);
        chk("s1 valid drop", 32'(out_valid),   32'd0);
        chk("s1 done",       32'(done),        32'd1);
        chk("s1 count",      32'(burst_count), 32'd1);
        @(negedge clk);
        chk("s1 done pulse", 32'(done), 32'd0);

        // backpressure burst 0x00, len 2
        issue(8'h00, 8'd2);
        @(negedge clk); cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            beat($sformatf("bp c%0d", i), bp_data[i], bp_last[i]);
            out_ready = bp_rdy[i];
            if (out_valid && out_ready) n_hs++;
        end
        @(negedge clk);
        chk("bp handshakes", 32'(n_hs),        32'd3);
        chk("bp valid drop", 32'(out_valid),   32'd0);
        chk("bp done",       32'(done),        32'd1);
        chk("bp count",      32'(burst_count), 32'd2);

        // back-to-back: A (0xF0, len 1) then B (0x05, len 0) during A's last beat
        issue(8'hF0, 8'd1);
        @(negedge clk); cmd_valid = 1'b0;
        beat("b2b a0", 8'hF0, 1'b0);
        @(negedge clk);
        beat("b2b a1", 8'hF1, 1'b1);
        issue(8'h05, 8'd0);
        @(negedge clk); cmd_valid = 1'b0;
        beat("b2b b0", 8'h05, 1'b1);
        chk("b2b done a", 32'(done),        32'd1);
        chk("b2b count a", 32'(burst_count), 32'd3);
        @(negedge clk);
        chk("b2b valid drop", 32'(out_valid),   32'd0);
        chk("b2b done b",     32'(done),        32'd1);
        chk("b2b count b",    32'(burst_count), 32'd4);

        // data wrap
        issue(8'hFE, 8'd2);
        @(negedge clk); cmd_valid = 1'b0;
        beat("wrap b0", 8'hFE, 1'b0);
        @(negedge clk); beat("wrap b1", 8'hFF, 1'b0);
        @(negedge clk); beat("wrap b2", 8'h00, 1'b1);
        @(negedge clk);
        chk("wrap count", 32'(burst_count), 32'd5);

        // maximum length: 256 beats
        issue(8'h00, 8'hFF);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); cmd_valid = 1'b0;
            d8 = 8'(i);
            beat($sformatf("max b%0d", i), d8, (i == 255));
        end
        @(negedge clk);
        chk("max valid drop", 32'(out_valid),   32'd0);
        chk("max count",      32'(burst_count), 32'd6);

        // reset mid-burst after 2 of 5 beats
        issue(8'h20, 8'd4);
        @(negedge clk); cmd_valid = 1'b0;
        beat("mr b0", 8'h20, 1'b0);
        @(negedge clk); beat("mr b1", 8'h21, 1'b0);
        @(negedge clk); beat("mr b2", 8'h22, 1'b0);
        #1 resetn = 1'b0;
        #1;
        chk("mr async valid", 32'(out_valid),   32'd0);
        chk("mr async data",  32'(out_data),    32'd0);
        chk("mr async count", 32'(burst_count), 32'd0);
        chk("mr cmd_ready",   32'(cmd_ready),   32'd0);
        @(negedge clk);
        chk("mr no done", 32'(done), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("mr idle ready", 32'(cmd_ready), 32'd1);
        chk("mr idle valid", 32'(out_valid), 32'd0);
        issue(8'h30, 8'd0);
        @(negedge clk); cmd_valid = 1'b0;
        beat("mr new b0", 8'h30, 1'b1);
        @(negedge clk);
        chk("mr new done",  32'(done),        32'd1);
        chk("mr new count", 32'(burst_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
